// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and its command responders.
// FSM encodings, responder opcode nibbles and an index-width helper.
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_Idle     = 2'd0,
    S_Issue    = 2'd1,
    S_WaitBusy = 2'd2,
    S_WaitDone = 2'd3
  } state_t;

  localparam logic [3:0] OP_PING     = 4'h1;
  localparam logic [3:0] OP_REG_READ = 4'h2;
  localparam logic [3:0] OP_STATUS   = 4'h3;

  // Width of a requester index; at least one bit so N=1 style corners still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pend searching last+1,
// last+2, ... modulo N.
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  int            j;
  logic [IW-1:0] jj;

  // Scan from farthest to nearest so the nearest pending requester overwrites.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int k = N; k >= 1; k--) begin
      j  = (int'(last) + k) % N;
      jj = IW'(j);
      if (pend[jj]) begin
        any = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one UART transmitter among N byte responders: per-requester holding
// slots, round-robin grant, one-cycle start strobe issued only while the UART is idle.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int BUSY_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*8-1:0] req_data,
  input  logic [N-1:0]   req_en,
  output logic [N-1:0]   req_busy,
  output logic [N-1:0]   req_ovf,
  output logic [7:0]     uart_tx_data,
  output logic           uart_tx_en,
  input  logic           uart_tx_busy,
  output state_t         fsm_state
);

  localparam int IW = idx_w(N);
  localparam int CW = $clog2(BUSY_WAIT + 1);

  // Handshake: a requester strobe is accepted whenever its slot is free (or being
  // freed this cycle); uart_tx_en is a single-cycle start, only when uart_tx_busy=0.
  state_t        state, state_nx;
  logic [N-1:0]  pend;
  logic [7:0]    slot [N];
  logic [IW-1:0] grant, last;
  logic [CW-1:0] wcnt;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          issue;
  logic [N-1:0]  clr;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .pend (pend),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign issue     = (state == S_Issue) && !uart_tx_busy;
  assign fsm_state = state;

  always_comb begin
    clr = '0;
    if (issue) clr[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_Idle;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_Idle:     if (pick_any) state_nx = S_Issue;
      S_Issue:    if (!uart_tx_busy) state_nx = S_WaitBusy;
      S_WaitBusy: begin
        if (uart_tx_busy)          state_nx = S_WaitDone;
        else if (wcnt <= CW'(1))   state_nx = S_Idle;
      end
      S_WaitDone: if (!uart_tx_busy) state_nx = S_Idle;
      default:    state_nx = S_Idle;
    endcase
  end

  // Registered FSM outputs: grant bookkeeping, busy-wait counter and UART strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= '0;
      last         <= IW'(N - 1);
      wcnt         <= '0;
      uart_tx_data <= '0;
      uart_tx_en   <= 1'b0;
    end else begin
      uart_tx_en <= 1'b0;
      case (state)
        S_Idle: if (pick_any) grant <= pick_idx;
        S_Issue: begin
          if (!uart_tx_busy) begin
            uart_tx_data <= slot[grant];
            uart_tx_en   <= 1'b1;
            wcnt         <= CW'(BUSY_WAIT);
          end
        end
        S_WaitBusy: begin
          if (!uart_tx_busy) begin
            if (wcnt <= CW'(1)) last <= grant;
            else                wcnt <= wcnt - CW'(1);
          end
        end
        S_WaitDone: if (!uart_tx_busy) last <= grant;
        default: ;
      endcase
    end
  end

  // A new strobe in the same cycle its slot is issued refills the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      req_ovf <= '0;
      for (int i = 0; i < N; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_en[i] && (!pend[i] || clr[i])) begin
          slot[i] <= req_data[i*8 +: 8];
          pend[i] <= 1'b1;
        end else if (req_en[i]) begin
          req_ovf[i] <= 1'b1;
        end else if (clr[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    req_busy = '0;
    for (int i = 0; i < N; i++)
      req_busy[i] = pend[i] | ((state != S_Idle) && (grant == IW'(i)));
  end

endmodule
